index_allocator: RTL
====================

# index_allocator

Slot index allocator: the index-producing and index-returning counterpart to the core's priority-encode helpers. It tracks a busy bitmap over NUM_SLOTS slots. It hands out the lowest-numbered free slot index on request, and it accepts returned indices that it decodes back into bitmap clears. Used by core queues (miss tracking, writeback buffers) that need a tag/slot number per outstanding entry.

## Interface
- INDEX_WIDTH, 3, width of slot indices.
- NUM_SLOTS, 1<<INDEX_WIDTH, number of slots; legal range 2..2^INDEX_WIDTH.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- alloc_req  in  1  request one slot this cycle.
- alloc_gnt  out  1  registered; request from previous cycle was granted.
- alloc_index  out  INDEX_WIDTH  registered; granted slot, valid when alloc_gnt=1.
- free_en  in  1  return a slot this cycle.
- free_index  in  INDEX_WIDTH  slot being returned.
- slot_busy  out  NUM_SLOTS  registered busy bitmap, bit i = slot i allocated.
- free_count  out  INDEX_WIDTH+1  registered count of non-busy slots.
- full  out  1  registered; free_count==0.
- empty  out  1  registered; free_count==NUM_SLOTS.
- free_error  out  1  registered one-cycle pulse; last free was illegal.

## Operation
- Allocation select: lowest i with slot_busy[i]==0, computed from the current (pre-edge) bitmap. Slots above NUM_SLOTS-1 never exist.
- alloc_req=1 and at least one free slot: at the edge, set slot_busy[i]. Next cycle alloc_gnt=1 and alloc_index=i.
- alloc_req=1 and full: no bitmap change. Next cycle alloc_gnt=0. No queuing; the requester retries.
- alloc_req=0: alloc_gnt=0 next cycle. alloc_index holds its last granted value.
- Free is legal when free_en=1, free_index<NUM_SLOTS and slot_busy[free_index]==1. At the edge, the decoded one-hot clears that bit.
- Illegal free (free_index>=NUM_SLOTS, or slot not busy): the bitmap is unchanged and free_error=1 for exactly the next cycle.
- Simultaneous alloc and free in one cycle: both take effect at the same edge.
  - Allocation sees only the pre-edge bitmap, so a slot freed this cycle is not grantable this cycle.
  - If full, the request is refused even though a free occurs in the same cycle.
  - Alloc and free cannot target the same slot, because alloc picks non-busy slots and a free of a non-busy slot is illegal.
- free_count next = free_count - granted + legal_free, computed in INDEX_WIDTH+1 bits. It never wraps. full and empty are derived from the next value and registered alongside it.
- Reset (reset=0 at an edge, including mid-operation):
  - slot_busy=0 and free_count=NUM_SLOTS.
  - alloc_gnt=0, alloc_index=0, free_error=0.
  - full=0, empty=1.
  - Requests presented during reset are discarded. Reset has priority over alloc and free.

## Timing
- Allocate: request in cycle N, grant and index in N+1. slot_busy, free_count, full and empty reflect the allocation in N+1.
- Free: in cycle N; the bitmap clear and count update are visible in N+1. The slot is grantable to a request made in N+1, with the grant in N+2.
- Throughput: one allocation and one free per cycle, sustained.
- No combinational path from any input to any output. All outputs are flops.

## Test plan
- Reset then sequential alloc, NUM_SLOTS=8: alloc_req=1 for 9 cycles.
  - Grants with indices 0..7 on cycles 2..9.
  - Cycle 10 alloc_gnt=0; full=1 from cycle 9, free_count=0.
  - slot_busy=8'hFF.
- Full, free 5 and alloc in the same cycle:
  - No grant next cycle; slot_busy=8'hDF, free_count=1.
  - Re-request next cycle: grant with index 5, full=1.
- Lowest-free selection: from full, free 6 then free 2 (separate cycles), then two requests.
  - Indices 2 then 6.
- Illegal frees, with slot_busy=8'h01:
  - Free index 3: free_error pulses one cycle, bitmap unchanged.
  - With NUM_SLOTS=6: free index 7 gives free_error, free_count unchanged.
- Mid-operation reset: 4 slots busy, alloc_req=1 with reset=0.
  - Next cycle slot_busy=0, free_count=8, empty=1, alloc_gnt=0.
  - After reset releases, the first grant has index 0.
- Random soak: 10k cycles of random alloc/free of busy slots.
  - popcount(slot_busy)+free_count==NUM_SLOTS every cycle.
  - No index is granted twice without an intervening free.

Source files
------------

// File: rtl/index_allocator_if.sv
// Allocate/free bundle for index_allocator.
// The master side requests and returns slots; the slave side is the allocator.
interface index_allocator_if #(
  parameter int INDEX_WIDTH = 3,
  parameter int NUM_SLOTS   = 1 << INDEX_WIDTH
);
  logic                   alloc_req;
  logic                   alloc_gnt;
  logic [INDEX_WIDTH-1:0] alloc_index;
  logic                   free_en;
  logic [INDEX_WIDTH-1:0] free_index;
  logic [NUM_SLOTS-1:0]   slot_busy;
  logic [INDEX_WIDTH:0]   free_count;
  logic                   full;
  logic                   empty;
  logic                   free_error;

  modport master (
    output alloc_req, free_en, free_index,
    input  alloc_gnt, alloc_index, slot_busy, free_count, full, empty, free_error
  );

  modport slave (
    input  alloc_req, free_en, free_index,
    output alloc_gnt, alloc_index, slot_busy, free_count, full, empty, free_error
  );
endinterface

// File: rtl/index_allocator.sv
// Slot index allocator: hands out the lowest free slot of a busy bitmap and
// takes returned indices back. Every output is a flop.
module index_allocator #(
  parameter int INDEX_WIDTH = 3,
  parameter int NUM_SLOTS   = 1 << INDEX_WIDTH
) (
  input logic              clk,
  input logic              reset,
  index_allocator_if.slave bus
);

  localparam int CW = INDEX_WIDTH + 1;

  logic [NUM_SLOTS-1:0]   busy_r;
  logic [CW-1:0]          count_r;
  logic                   gnt_r;
  logic [INDEX_WIDTH-1:0] index_r;
  logic                   full_r;
  logic                   empty_r;
  logic                   ferr_r;

  logic                   found_s;
  logic [INDEX_WIDTH-1:0] pick_s;
  logic                   grant_s;
  logic [NUM_SLOTS-1:0]   free_dec_s;
  logic                   free_legal_s;
  logic [NUM_SLOTS-1:0]   busy_nxt_s;
  logic [CW-1:0]          count_nxt_s;

  // Index -> one-hot over the existing slots; indices past the last slot decode to zero.
  function automatic logic [NUM_SLOTS-1:0] decode_onehot(input logic [INDEX_WIDTH-1:0] idx);
    logic [NUM_SLOTS-1:0] dec;
    dec = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dec[i] = (INDEX_WIDTH'(i) == idx);
    end
    return dec;
  endfunction

  // Lowest free slot of the pre-edge bitmap; the first free slot seen locks the choice.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {INDEX_WIDTH{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pick_s  = (!busy_r[i] && !found_s) ? INDEX_WIDTH'(i) : pick_s;
      found_s = found_s | ~busy_r[i];
    end
  end

  // Next bitmap and count from the grant and a legal free (never the same slot).
  always_comb begin
    grant_s      = bus.alloc_req & found_s;
    free_dec_s   = decode_onehot(bus.free_index);
    free_legal_s = bus.free_en & (|(free_dec_s & busy_r));
    busy_nxt_s   = busy_r;
    if (grant_s) begin
      busy_nxt_s = busy_nxt_s | decode_onehot(pick_s);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (free_legal_s) begin
      busy_nxt_s = busy_nxt_s & ~free_dec_s;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    count_nxt_s = count_r - CW'(grant_s) + CW'(free_legal_s);
  end

  // State and output registers; reset wins over any request or free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_r  <= {NUM_SLOTS{1'b0}};
      count_r <= CW'(NUM_SLOTS);
      gnt_r   <= 1'b0;
      index_r <= {INDEX_WIDTH{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ferr_r  <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
      gnt_r   <= grant_s;
      if (grant_s) begin
        index_r <= pick_s;
      end else begin
        index_r <= index_r;
      end
      full_r  <= (count_nxt_s == {CW{1'b0}});
      empty_r <= (count_nxt_s == CW'(NUM_SLOTS));
      ferr_r  <= bus.free_en & ~free_legal_s;
    end
  end

  assign bus.slot_busy   = busy_r;
  assign bus.free_count  = count_r;
  assign bus.alloc_gnt   = gnt_r;
  assign bus.alloc_index = index_r;
  assign bus.full        = full_r;
  assign bus.empty       = empty_r;
  assign bus.free_error  = ferr_r;

endmodule
